// File: rtl/mbox_responder.sv
// mbox_responder
//   Answers single-word EBOX memory requests after a configurable latency.
//   One request is active at a time; one further request can wait in a
//   one-entry pending buffer. A request can be forced to page-fail. It is
//   then held until the EBOX acknowledges it, and no response pulse is sent.
//
// Ports
//   clk            : sole clock, rising edge
//   rst_n          : asynchronous active-low reset
//   ebox_req       : one-cycle request strobe
//   ebox_write     : request is a write (sampled with ebox_req)
//   ebox_vma       : request address; [8] is VMA bit 27, [0] is VMA bit 35
//   pf_inject      : force a page fail on this request
//   pf_ebox_handle : EBOX has taken the page fail (ignored outside PFAIL)
//   lat_cfg        : response latency, 0..3 wait cycles
//   nxm_limit      : lowest nonexistent address
//   mbox_resp_in   : one-cycle response pulse
//   mbox_gate_vma  : VMA of the active (or last) request
//   page_fail_hold : page fail pending
//   pf_disp        : page-fail dispatch word {write, 1, vma}
//   nxm_err        : nonexistent memory, valid with mbox_resp_in
//   par_bit_a      : odd parity over VMA bits 27:31
//   par_bit_b      : odd parity over VMA bits 32:35
//   busy           : a request is active or pending
module mbox_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ebox_req,
  input  logic        ebox_write,
  input  logic [8:0]  ebox_vma,
  input  logic        pf_inject,
  input  logic        pf_ebox_handle,
  input  logic [1:0]  lat_cfg,
  input  logic [8:0]  nxm_limit,
  output logic        mbox_resp_in,
  output logic [8:0]  mbox_gate_vma,
  output logic        page_fail_hold,
  output logic [10:0] pf_disp,
  output logic        nxm_err,
  output logic        par_bit_a,
  output logic        par_bit_b,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_PFAIL = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;

  // Active request
  logic [8:0]  act_vma_reg, act_vma_next;
  logic        act_write_reg, act_write_next;
  logic        act_pf_reg, act_pf_next;
  logic        act_nxm_reg, act_nxm_next;

  // Pending buffer
  logic        pend_valid_reg, pend_valid_next;
  logic        pend_write_reg, pend_write_next;
  logic [8:0]  pend_vma_reg, pend_vma_next;
  logic        pend_pf_reg, pend_pf_next;

  // Source of a new active request (either the EBOX or the pending buffer)
  logic        load_act;
  logic [8:0]  ld_vma;
  logic        ld_write;
  logic        ld_pf;
  logic        exit_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 2'd0;
      act_vma_reg    <= 9'd0;
      act_write_reg  <= 1'b0;
      act_pf_reg     <= 1'b0;
      act_nxm_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_write_reg <= 1'b0;
      pend_vma_reg   <= 9'd0;
      pend_pf_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      act_vma_reg    <= act_vma_next;
      act_write_reg  <= act_write_next;
      act_pf_reg     <= act_pf_next;
      act_nxm_reg    <= act_nxm_next;
      pend_valid_reg <= pend_valid_next;
      pend_write_reg <= pend_write_next;
      pend_vma_reg   <= pend_vma_next;
      pend_pf_reg    <= pend_pf_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    act_vma_next    = act_vma_reg;
    act_write_next  = act_write_reg;
    act_pf_next     = act_pf_reg;
    act_nxm_next    = act_nxm_reg;
    pend_valid_next = pend_valid_reg;
    pend_write_next = pend_write_reg;
    pend_vma_next   = pend_vma_reg;
    pend_pf_next    = pend_pf_reg;
    load_act        = 1'b0;
    ld_vma          = ebox_vma;
    ld_write        = ebox_write;
    ld_pf           = pf_inject;
    exit_now        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (ebox_req) begin
          load_act = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 2'd1;
        // Leaving at count 1 gives lat_cfg+1 cycles from strobe to response.
        if (cnt_reg <= 2'd1) begin
          state_next = act_pf_reg ? ST_PFAIL : ST_RESP;
        end
      end
      ST_RESP: begin
        exit_now = 1'b1;
      end
      ST_PFAIL: begin
        if (pf_ebox_handle) begin
          exit_now = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (exit_now) begin
      if (pend_valid_reg) begin
        load_act        = 1'b1;
        ld_vma          = pend_vma_reg;
        ld_write        = pend_write_reg;
        ld_pf           = pend_pf_reg;
        pend_valid_next = 1'b0;
      end else if (ebox_req) begin
        // A strobe coinciding with an exit and an empty buffer goes straight
        // to the active registers.
        load_act = 1'b1;
      end else begin
        state_next = ST_IDLE;
      end
    end

    // A strobe while busy is parked in the buffer if there is room. If the
    // buffer is full, the request is dropped and nothing else changes.
    if (ebox_req && (state_reg != ST_IDLE) && !pend_valid_reg && !exit_now) begin
      pend_valid_next = 1'b1;
      pend_write_next = ebox_write;
      pend_vma_next   = ebox_vma;
      pend_pf_next    = pf_inject;
    end

    if (load_act) begin
      act_vma_next   = ld_vma;
      act_write_next = ld_write;
      act_pf_next    = ld_pf;
      act_nxm_next   = (ld_vma >= nxm_limit);
      cnt_next       = lat_cfg;
      if (lat_cfg != 2'd0) begin
        state_next = ST_WAIT;
      end else begin
        state_next = ld_pf ? ST_PFAIL : ST_RESP;
      end
    end
  end

  assign mbox_resp_in   = (state_reg == ST_RESP);
  assign nxm_err        = (state_reg == ST_RESP) && act_nxm_reg;
  assign page_fail_hold = (state_reg == ST_PFAIL);
  assign pf_disp        = (state_reg == ST_PFAIL) ? {act_write_reg, 1'b1, act_vma_reg} : 11'd0;
  assign mbox_gate_vma  = act_vma_reg;
  assign busy           = (state_reg != ST_IDLE) || pend_valid_reg;

  // Odd parity: the bit is 1 when its field holds an even number of ones.
  assign par_bit_a = ~^mbox_gate_vma[8:4];
  assign par_bit_b = ~^mbox_gate_vma[3:0];

endmodule

// File: doc/mbox_responder.md
MBOX_RESPONDER -- requirements
Module: mbox_responder

Interface
REQ-001 The block SHALL have exactly one clock and one reset.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low; assert asynchronously, deassert synchronous to clk.
REQ-002 EBOX-side request inputs SHALL be:
- ebox_req  in  1  one-cycle request strobe.
- ebox_write  in  1  request is a write (sampled with ebox_req).
- ebox_vma  in  9  request address, bits 27:35.
- pf_inject  in  1  force page fail on this request (sampled with ebox_req).
- pf_ebox_handle  in  1  EBOX has taken the page fail; releases hold.
REQ-003 Configuration inputs SHALL be:
- lat_cfg  in  2  response latency select: 0..3 wait cycles.
- nxm_limit  in  9  lowest nonexistent address.
REQ-004 Response outputs SHALL be:
- mbox_resp_in  out  1  one-cycle response pulse.
- mbox_gate_vma  out  9  VMA of the request being answered.
- page_fail_hold  out  1  page fail pending.
- pf_disp  out  11  page-fail dispatch word.
- nxm_err  out  1  nonexistent-memory flag, same cycle as the response.
- par_bit_a  out  1  parity of mbox_gate_vma[27:31].
- par_bit_b  out  1  parity of mbox_gate_vma[32:35].
- busy  out  1  a request is active or pending.

Function
REQ-005 The block SHALL implement states IDLE, WAIT, RESP and PFAIL, plus a one-entry pending buffer (valid, write, vma, pf).
REQ-006 In IDLE, ebox_req SHALL load the active registers (vma, write, pf, nxm = ebox_vma >= nxm_limit, unsigned 9-bit compare) and load the latency counter from lat_cfg.
- Next state SHALL be WAIT if lat_cfg > 0.
- Otherwise next state SHALL be PFAIL if pf_inject = 1, else RESP.
REQ-007 In WAIT, the counter SHALL decrement by 1 each cycle.
- When the counter reaches 1, next state SHALL be PFAIL if the active pf flag = 1, else RESP.
- Total latency from the ebox_req cycle to mbox_resp_in SHALL be lat_cfg + 1 cycles.
REQ-008 In RESP, the block SHALL drive the following for exactly one cycle:
- mbox_resp_in = 1.
- nxm_err = active nxm flag.
- mbox_gate_vma = active vma.
REQ-009 On leaving RESP, if the pending buffer is valid, its contents SHALL be promoted to the active registers.
- The counter SHALL be reloaded from the current lat_cfg.
- The pending buffer SHALL be cleared.
- State transitions SHALL follow REQ-006 rules.
- If the pending buffer is not valid, next state SHALL be IDLE.
REQ-010 In PFAIL, page_fail_hold SHALL be 1.
- pf_disp SHALL equal {active write, 1'b1, active vma}.
- mbox_resp_in SHALL stay 0.
- The state SHALL persist until pf_ebox_handle = 1, then take the exit of REQ-009.
REQ-011 ebox_req outside IDLE SHALL load the pending buffer if it is empty.
- If the pending buffer is already full, the request SHALL be dropped.
- A dropped request SHALL leave all existing state unchanged.
REQ-012 ebox_req in the same cycle as a RESP or PFAIL exit with an empty buffer SHALL be accepted directly as the next active request. It SHALL not be lost.
REQ-013 mbox_gate_vma SHALL hold the active vma in all non-IDLE states. It SHALL hold the last value in IDLE.
- par_bit_a SHALL be odd parity: 1 when mbox_gate_vma[27:31] has an even count of ones.
- par_bit_b SHALL be odd parity over mbox_gate_vma[32:35].
- Both parity bits SHALL be combinational from mbox_gate_vma.
REQ-014 busy SHALL be 1 when state is not IDLE or the pending buffer is valid.
REQ-015 pf_ebox_handle outside PFAIL SHALL be ignored.

Reset
REQ-016 rst_n = 0 SHALL immediately force:
- state to IDLE and pending valid to 0.
- counter to 0.
- mbox_resp_in, page_fail_hold, nxm_err and busy to 0.
- mbox_gate_vma and pf_disp to 0.
- As a result, par_bit_a = 1 and par_bit_b = 1.
REQ-017 A reset mid-transaction SHALL discard both active and pending requests. No response SHALL follow reset release.

Verification
REQ-018 lat_cfg = 2, ebox_req with vma = 0x0A5 in cycle 0 -> mbox_resp_in = 1 only in cycle 3, mbox_gate_vma = 0x0A5, nxm_err = 0.
REQ-019 lat_cfg = 0, nxm_limit = 0x100, vma = 0x1FF -> response next cycle with nxm_err = 1; vma = 0x0FF -> nxm_err = 0.
REQ-020 pf_inject = 1, ebox_write = 1, vma = 0x012 -> page_fail_hold = 1 and pf_disp = 0x612 until pf_ebox_handle, with no mbox_resp_in; hold drops the cycle after pf_ebox_handle.
REQ-021 Three back-to-back requests A, B, C during WAIT (lat_cfg = 3) -> responses for A then B only, C dropped, busy = 0 after B.
REQ-022 rst_n pulsed low during WAIT with a pending request -> all outputs at reset values, no response for 10 cycles after release.
REQ-023 vma = 0x000 -> par_bit_a = 1, par_bit_b = 1; vma = 0x1F0 -> par_bit_a = 0, par_bit_b = 1.
